// File: rtl/muldiv_unit_pkg.sv
// Shared op codes and FSM states for the iterative multiply/divide unit.
// Signed ops are enabled by defining MULDIV_SIGNED_EN.
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV_S,
    MD_FIXUP
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the control path and the muldiv unit.
// Used with MULDIV_SIGNED_EN on or off; the bundle is identical.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_cond_negate.sv
// Conditional two's-complement negate, used for operand abs and result fixup.
// Only instantiated when MULDIV_SIGNED_EN is defined.
module muldiv_cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? -in_i : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Radix-2 iterative mul/div with HI/LO registers: WIDTH iterations + fixup.
// Define MULDIV_SIGNED_EN to make op 01/11 signed.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               isdiv_q, isdiv_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_dif;
  logic               div_ge;

`ifdef MULDIV_SIGNED_EN
  logic sa, sb;
  logic negq_q, negr_q;

  assign sa = bus.op[0] & bus.a[WIDTH-1];
  assign sb = bus.op[0] & bus.b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (state_q == MD_IDLE && bus.start) begin
      negq_q <= sa ^ sb;
      negr_q <= sa;
    end
  end

  muldiv_cond_negate #(.W(WIDTH)) u_abs_a (
    .in_i (bus.a),
    .neg_i(sa),
    .out_o(a_abs)
  );

  muldiv_cond_negate #(.W(WIDTH)) u_abs_b (
    .in_i (bus.b),
    .neg_i(sb),
    .out_o(b_abs)
  );

  muldiv_cond_negate #(.W(2*WIDTH)) u_fix_p (
    .in_i (prod_q),
    .neg_i(negq_q),
    .out_o(prod_fix)
  );

  muldiv_cond_negate #(.W(WIDTH)) u_fix_q (
    .in_i (prod_q[WIDTH-1:0]),
    .neg_i(negq_q),
    .out_o(quo_fix)
  );

  muldiv_cond_negate #(.W(WIDTH)) u_fix_r (
    .in_i (prod_q[2*WIDTH-1:WIDTH]),
    .neg_i(negr_q),
    .out_o(rem_fix)
  );
`else
  assign a_abs    = bus.a;
  assign b_abs    = bus.b;
  assign prod_fix = prod_q;
  assign quo_fix  = prod_q[WIDTH-1:0];
  assign rem_fix  = prod_q[2*WIDTH-1:WIDTH];
`endif

  // prod_q: mul = {partial, multiplier}; div = {remainder, dividend/quotient}
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, opnd_q};
  assign div_sh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  assign div_dif = div_sh - {1'b0, opnd_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    isdiv_d = isdiv_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      MD_IDLE: begin
        if (bus.start) begin
          isdiv_d = md_is_div(bus.op);
          cnt_d   = '0;
          if (md_is_div(bus.op)) begin
            opnd_d  = b_abs;
            prod_d  = {{WIDTH{1'b0}}, a_abs};
            state_d = MD_DIV_S;
          end else begin
            opnd_d  = a_abs;
            prod_d  = {{WIDTH{1'b0}}, b_abs};
            state_d = MD_MUL;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      MD_MUL: begin
        if (prod_q[0]) begin
          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end else begin
          prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = MD_FIXUP;
      end
      MD_DIV_S: begin
        if (div_ge) begin
          prod_d = {div_dif[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
          prod_d = {div_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = MD_FIXUP;
      end
      MD_FIXUP: begin
        done_d  = 1'b1;
        state_d = MD_IDLE;
        dz_d    = isdiv_q && (opnd_q == '0);
        if (isdiv_q) begin
          hi_d = rem_fix;
          lo_d = (opnd_q == '0) ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      isdiv_q <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      isdiv_q <= isdiv_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = (state_q != MD_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc;
  logic saw_done;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) m ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y);
    m.start = 1'b1;
    m.op    = o;
    m.a     = x;
    m.b     = y;
    tick();
    m.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (m.done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    launch(o, x, y);
    chk({tag, "_busy"}, 64'(m.busy), 64'd1);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd33);
    chk({tag, "_hi"}, 64'(m.hi), 64'(ehi));
    chk({tag, "_lo"}, 64'(m.lo), 64'(elo));
  endtask

  initial begin
    reset   = 1'b1;
    m.start = 1'b0;
    m.op    = 2'b00;
    m.a     = '0;
    m.b     = '0;
    m.hi_we = 1'b0;
    m.lo_we = 1'b0;
    m.wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_done", 64'(m.done), 64'd0);
    chk("rst_dz", 64'(m.div_zero), 64'd0);
    chk("rst_hi", 64'(m.hi), 64'd0);
    chk("rst_lo", 64'(m.lo), 64'd0);

    run("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001);
    chk("multu_done", 64'(m.done), 64'd1);
    chk("multu_busy0", 64'(m.busy), 64'd0);
    tick();
    chk("done_pulse", 64'(m.done), 64'd0);

`ifdef MULDIV_SIGNED_EN
    run("mult_neg", 2'b01, 32'hFFFFFFF9, 32'd6,
        32'hFFFFFFFF, 32'hFFFFFFD6);
    run("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD);
    run("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF,
        32'h00000000, 32'h80000000);
`else
    run("mult_neg", 2'b01, 32'hFFFFFFF9, 32'd6,
        32'h00000005, 32'hFFFFFFD6);
    run("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2,
        32'h00000001, 32'h7FFFFFFC);
    run("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 32'h00000000);
`endif
    run("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    chk("divu_dz", 64'(m.div_zero), 64'd0);

    run("divz", 2'b10, 32'd123, 32'd0, 32'd123, 32'hFFFFFFFF);
    chk("divz_dz", 64'(m.div_zero), 64'd1);
    tick();
    chk("divz_hold", 64'(m.div_zero), 64'd1);
    run("divu8", 2'b10, 32'd8, 32'd2, 32'd0, 32'd4);
    chk("divu8_dz", 64'(m.div_zero), 64'd0);

    // second start mid-op must not disturb the running multiply
    launch(2'b00, 32'd3, 32'd5);
    repeat (4) tick();
    launch(2'b10, 32'd100, 32'd7);
    chk("ign_busy", 64'(m.busy), 64'd1);
    chk("ign_hold_lo", 64'(m.lo), 64'd4);
    wait_done(cyc);
    chk("ign_lat", 64'(cyc), 64'd28);
    chk("ign_hi", 64'(m.hi), 64'd0);
    chk("ign_lo", 64'(m.lo), 64'd15);

    tick();
    launch(2'b00, 32'd9, 32'd9);
    repeat (4) tick();
    launch(2'b10, 32'd100, 32'd7);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(m.busy), 64'd0);
    chk("abort_hi", 64'(m.hi), 64'd0);
    chk("abort_lo", 64'(m.lo), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      tick();
      saw_done = saw_done | m.done;
    end
    chk("abort_nodone", 64'(saw_done), 64'd0);

    launch(2'b00, 32'd2, 32'd3);
    repeat (2) tick();
    m.hi_we = 1'b1;
    m.wdata = 32'hA5A5A5A5;
    tick();
    m.hi_we = 1'b0;
    chk("mthi_busy", 64'(m.hi), 64'd0);
    wait_done(cyc);
    chk("mthi_res_lo", 64'(m.lo), 64'd6);
    tick();
    m.hi_we = 1'b1;
    m.wdata = 32'hA5A5A5A5;
    launch(2'b00, 32'd0, 32'd0);
    m.hi_we = 1'b0;
    chk("mthi_start", 64'(m.hi), 64'd0);
    wait_done(cyc);
    chk("mthi_start_hi", 64'(m.hi), 64'd0);
    tick();
    m.hi_we = 1'b1;
    tick();
    m.hi_we = 1'b0;
    chk("mthi_idle", 64'(m.hi), 64'hA5A5A5A5);
    chk("mthi_lo_keep", 64'(m.lo), 64'd0);
    m.hi_we = 1'b1;
    m.lo_we = 1'b1;
    m.wdata = 32'h12345678;
    tick();
    m.hi_we = 1'b0;
    m.lo_we = 1'b0;
    chk("both_hi", 64'(m.hi), 64'h12345678);
    chk("both_lo", 64'(m.lo), 64'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
